// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/response handshake between the fetch controller and imem.
// The requester holds req/addr steady until ready completes the transfer.
interface fetch_ctrl_if;
   logic        req;
   logic [31:0] addr;
   logic        ready;
   logic [31:0] rdata;

   modport master (output req, output addr, input ready, input rdata);
   modport slave  (input req, input addr, output ready, output rdata);
endinterface

// File: rtl/fetch_ctrl.sv
// IF-stage sequencer: owns the PC, talks to a variable-latency imem, buffers a word while
// stalled and drains a fetch that a D-stage redirect has made stale.
module fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               stall_f,
   input  logic               pc_src_d,
   input  logic [31:0]        pc_branch_d,
   input  logic [1:0]         jump,
   input  logic [31:0]        instr_d,
   input  logic [31:0]        reg_src_a_d,
   fetch_ctrl_if.master       imem,
   output logic [31:0]        pc_f,
   output logic [31:0]        pc_plus_4_f,
   output logic [31:0]        instr_f,
   output logic               instr_valid_f,
   output logic               flush_d
);

   typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_t;

   state_t      state, state_next;
   logic [31:0] pc, pc_next;
   logic [31:0] buf_word, buf_next;
   logic [31:0] old_addr, old_addr_next;
   logic        redirect;
   logic [31:0] target;

   // Only the j/jal index field of instr_d is used.
   logic unused_instr_bits;
   assign unused_instr_bits = ^instr_d[31:26];

   assign pc_f        = pc;
   assign pc_plus_4_f = pc + 32'd4;

   always_comb begin
      redirect = ~reset & ~stall_f & (pc_src_d | (jump == 2'd1) | (jump == 2'd2));
      case (jump)
         2'd2:    target = reg_src_a_d;
         2'd1:    target = {pc_plus_4_f[31:28], instr_d[25:0], 2'b00};
         default: target = pc_branch_d;
      endcase
   end

   always_comb begin
      state_next    = state;
      pc_next       = pc;
      buf_next      = buf_word;
      old_addr_next = old_addr;
      imem.req      = 1'b0;
      imem.addr     = pc;
      instr_f       = 32'd0;
      instr_valid_f = 1'b0;
      flush_d       = redirect;

      case (state)
         FETCH: begin
            imem.req      = 1'b1;
            instr_valid_f = imem.ready;
            instr_f       = imem.rdata;
            if (imem.ready) begin
               if (redirect) begin
                  pc_next = target;
               end else if (stall_f) begin
                  buf_next   = imem.rdata;
                  state_next = HOLD;
               end else begin
                  pc_next = pc_plus_4_f;
               end
            end else if (redirect) begin
               old_addr_next = pc;
               pc_next       = target;
               state_next    = DRAIN;
            end
         end
         HOLD: begin
            instr_valid_f = 1'b1;
            instr_f       = buf_word;
            if (redirect) begin
               pc_next    = target;
               state_next = FETCH;
            end else if (!stall_f) begin
               pc_next    = pc_plus_4_f;
               state_next = FETCH;
            end
         end
         DRAIN: begin
            // The stale request must stay on the bus unchanged until imem completes it.
            imem.req  = 1'b1;
            imem.addr = old_addr;
            if (redirect) begin
               pc_next = target;
            end
            if (imem.ready) begin
               state_next = FETCH;
            end
         end
         default: state_next = FETCH;
      endcase

      if (reset) begin
         imem.req      = 1'b0;
         instr_valid_f = 1'b0;
         instr_f       = 32'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= FETCH;
         pc       <= RESET_PC;
         buf_word <= 32'd0;
         old_addr <= 32'd0;
      end else begin
         state    <= state_next;
         pc       <= pc_next;
         buf_word <= buf_next;
         old_addr <= old_addr_next;
      end
   end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed stimulus pushes expected (pc, instr) pairs into a scoreboard
// that a monitor pops on every consumed instruction; a small imem model supplies wait states.
module tb_fetch_ctrl;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall_f;
   logic        pc_src_d;
   logic [31:0] pc_branch_d;
   logic [1:0]  jump;
   logic [31:0] instr_d;
   logic [31:0] reg_src_a_d;
   logic [31:0] pc_f;
   logic [31:0] pc_plus_4_f;
   logic [31:0] instr_f;
   logic        instr_valid_f;
   logic        flush_d;

   int          assert_count = 0;
   int          fail_count   = 0;
   exp_t        exp_q[$];

   int          mem_wait = 0;
   int          wait_cnt = 0;
   logic        force_ready = 1'b0;
   logic        ovr_en = 1'b0;
   logic [31:0] ovr_data = 32'd0;
   logic        prev_wait = 1'b0;
   logic [31:0] held_addr = 32'd0;

   fetch_ctrl_if imem ();

   fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
      .clk           (clk),
      .reset         (reset),
      .stall_f       (stall_f),
      .pc_src_d      (pc_src_d),
      .pc_branch_d   (pc_branch_d),
      .jump          (jump),
      .instr_d       (instr_d),
      .reg_src_a_d   (reg_src_a_d),
      .imem          (imem.master),
      .pc_f          (pc_f),
      .pc_plus_4_f   (pc_plus_4_f),
      .instr_f       (instr_f),
      .instr_valid_f (instr_valid_f),
      .flush_d       (flush_d)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] memWord(input logic [31:0] addr);
      return 32'hC000_0000 | addr;
   endfunction

   // Imem model: ready after mem_wait cycles of a held request; data is derived from the address.
   assign imem.ready = force_ready | (imem.req & (wait_cnt >= mem_wait));
   assign imem.rdata = ovr_en ? ovr_data : memWord(imem.addr);

   always @(posedge clk) begin
      if (reset || !imem.req || imem.ready) wait_cnt <= 0;
      else                                  wait_cnt <= wait_cnt + 1;
      prev_wait <= imem.req & ~imem.ready;
      held_addr <= imem.addr;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      assert_count++;
      if (actual !== expected) begin
         fail_count++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic stall, input logic src, input logic [31:0] branch,
                                input logic [1:0] jmp, input logic [31:0] instr,
                                input logic [31:0] rs);
      stall_f     = stall;
      pc_src_d    = src;
      pc_branch_d = branch;
      jump        = jmp;
      instr_d     = instr;
      reg_src_a_d = rs;
   endtask

   task automatic pushExp(input logic [31:0] pc, input logic [31:0] instr);
      exp_t e;
      e.pc    = pc;
      e.instr = instr;
      exp_q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Handshake stability: a request left waiting must reappear with the same address.
   always @(negedge clk) begin
      if (imem.req && prev_wait)
         checkOutput("addr_stable", imem.addr, held_addr);
   end

   // Scoreboard monitor: every instruction consumed by the IF/ID register is checked in order.
   always @(negedge clk) begin
      exp_t e;
      if (instr_valid_f && !stall_f && !flush_d) begin
         if (exp_q.size() == 0) begin
            assert_count++;
            fail_count++;
            $display("[TB] FAIL unexpected_consume: got pc 0x%08h, expected no instruction", pc_f);
         end else begin
            e = exp_q.pop_front();
            checkOutput("sb_pc", pc_f, e.pc);
            checkOutput("sb_instr", instr_f, e.instr);
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset = 1'b1;
      applyStimulus(1'b0, 1'b1, 32'h100, 2'd2, 32'd0, 32'h40);
      repeat (2) tick();
      @(negedge clk);
      checkOutput("reset_req",   {31'd0, imem.req}, 32'd0);
      checkOutput("reset_valid", {31'd0, instr_valid_f}, 32'd0);
      checkOutput("reset_flush", {31'd0, flush_d}, 32'd0);
      checkOutput("reset_instr", instr_f, 32'd0);
      tick();

      $display("[TB] zero-wait sequential fetch");
      reset = 1'b0;
      applyStimulus(1'b0, 1'b0, 32'd0, 2'd0, 32'd0, 32'd0);
      pushExp(32'h00, memWord(32'h00));
      pushExp(32'h04, memWord(32'h04));
      pushExp(32'h08, memWord(32'h08));
      pushExp(32'h0C, memWord(32'h0C));
      repeat (4) begin
         @(negedge clk);
         tick();
      end

      $display("[TB] two wait cycles per fetch");
      mem_wait = 2;
      pushExp(32'h10, memWord(32'h10));
      pushExp(32'h14, memWord(32'h14));
      pushExp(32'h18, memWord(32'h18));
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         checkOutput("valid_pulse", {31'd0, instr_valid_f}, (i % 3 == 2) ? 32'd1 : 32'd0);
         checkOutput("addr_wait", imem.addr, 32'h10 + 32'(4 * (i / 3)));
         tick();
      end

      $display("[TB] stall holds fetched word");
      mem_wait = 0;
      ovr_en   = 1'b1;
      ovr_data = 32'h2002_0005;
      applyStimulus(1'b1, 1'b0, 32'd0, 2'd0, 32'd0, 32'd0);
      @(negedge clk);
      checkOutput("stall_instr", instr_f, 32'h2002_0005);
      tick();
      ovr_en = 1'b0;
      repeat (2) begin
         @(negedge clk);
         checkOutput("hold_req",   {31'd0, imem.req}, 32'd0);
         checkOutput("hold_instr", instr_f, 32'h2002_0005);
         checkOutput("hold_pc",    pc_f, 32'h1C);
         tick();
      end
      applyStimulus(1'b0, 1'b0, 32'd0, 2'd0, 32'd0, 32'd0);
      pushExp(32'h1C, 32'h2002_0005);
      @(negedge clk);
      tick();

      $display("[TB] jr beats branch, stall blocks redirect");
      applyStimulus(1'b0, 1'b1, 32'h100, 2'd2, 32'd0, 32'h40);
      @(negedge clk);
      checkOutput("jr_flush", {31'd0, flush_d}, 32'd1);
      checkOutput("jr_pc_before", pc_f, 32'h20);
      tick();
      applyStimulus(1'b1, 1'b1, 32'h100, 2'd2, 32'd0, 32'h80);
      @(negedge clk);
      checkOutput("jr_pc_after", pc_f, 32'h40);
      checkOutput("stall_no_flush", {31'd0, flush_d}, 32'd0);
      tick();
      @(negedge clk);
      checkOutput("stall_no_redirect", pc_f, 32'h40);
      checkOutput("stall_hold_req", {31'd0, imem.req}, 32'd0);
      tick();
      applyStimulus(1'b0, 1'b0, 32'd0, 2'd0, 32'd0, 32'd0);
      pushExp(32'h40, memWord(32'h40));
      @(negedge clk);
      tick();

      $display("[TB] j, reserved jump and branch");
      applyStimulus(1'b0, 1'b0, 32'd0, 2'd1, 32'h0C00_0030, 32'd0);
      @(negedge clk);
      checkOutput("j_flush", {31'd0, flush_d}, 32'd1);
      tick();
      applyStimulus(1'b0, 1'b0, 32'h500, 2'd3, 32'd0, 32'h600);
      pushExp(32'hC0, memWord(32'hC0));
      @(negedge clk);
      checkOutput("j_target", pc_f, 32'hC0);
      checkOutput("rsvd_no_flush", {31'd0, flush_d}, 32'd0);
      tick();
      applyStimulus(1'b0, 1'b1, 32'h10, 2'd0, 32'd0, 32'd0);
      @(negedge clk);
      checkOutput("rsvd_seq_pc", pc_f, 32'hC4);
      checkOutput("br_flush", {31'd0, flush_d}, 32'd1);
      tick();

      $display("[TB] redirect with a request outstanding");
      mem_wait = 3;
      applyStimulus(1'b0, 1'b0, 32'd0, 2'd0, 32'd0, 32'd0);
      @(negedge clk);
      checkOutput("br_target", pc_f, 32'h10);
      checkOutput("wait_valid", {31'd0, instr_valid_f}, 32'd0);
      tick();
      applyStimulus(1'b0, 1'b1, 32'h80, 2'd0, 32'd0, 32'd0);
      @(negedge clk);
      checkOutput("drain_entry_flush", {31'd0, flush_d}, 32'd1);
      tick();
      applyStimulus(1'b0, 1'b0, 32'd0, 2'd2, 32'd0, 32'h90);
      @(negedge clk);
      checkOutput("drain_addr", imem.addr, 32'h10);
      checkOutput("drain_req", {31'd0, imem.req}, 32'd1);
      checkOutput("drain_valid", {31'd0, instr_valid_f}, 32'd0);
      checkOutput("drain_pc", pc_f, 32'h80);
      checkOutput("drain_flush", {31'd0, flush_d}, 32'd1);
      tick();
      applyStimulus(1'b0, 1'b0, 32'd0, 2'd0, 32'd0, 32'd0);
      @(negedge clk);
      checkOutput("drain_done_valid", {31'd0, instr_valid_f}, 32'd0);
      checkOutput("drain_done_addr", imem.addr, 32'h10);
      checkOutput("drain_last_pc", pc_f, 32'h90);
      tick();
      mem_wait = 0;
      pushExp(32'h90, memWord(32'h90));
      @(negedge clk);
      checkOutput("post_drain_addr", imem.addr, 32'h90);
      tick();

      $display("[TB] reset while draining");
      mem_wait = 3;
      applyStimulus(1'b0, 1'b1, 32'h300, 2'd0, 32'd0, 32'd0);
      @(negedge clk);
      checkOutput("drain2_flush", {31'd0, flush_d}, 32'd1);
      tick();
      reset       = 1'b1;
      force_ready = 1'b1;
      applyStimulus(1'b0, 1'b0, 32'd0, 2'd0, 32'd0, 32'd0);
      @(negedge clk);
      checkOutput("rst_drain_req",   {31'd0, imem.req}, 32'd0);
      checkOutput("rst_drain_valid", {31'd0, instr_valid_f}, 32'd0);
      checkOutput("rst_drain_instr", instr_f, 32'd0);
      tick();
      reset       = 1'b0;
      force_ready = 1'b0;
      @(negedge clk);
      checkOutput("rst_pc",    pc_f, 32'h0);
      checkOutput("rst_req",   {31'd0, imem.req}, 32'd1);
      checkOutput("rst_addr",  imem.addr, 32'h0);
      checkOutput("rst_valid", {31'd0, instr_valid_f}, 32'd0);
      tick();

      checkOutput("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
      $finish;
   end

endmodule
